// File: rtl/fx2_slavefifo_arbiter_if.sv
// ---------------------------------------------------------------------------
// fx2_slavefifo_arbiter_if
// Bundles the FX2 slave-FIFO pad-side bus and the two stream handshakes that
// the arbiter sequences.
//   master : arbiter side (drives FX2 strobes/address, rx stream, tx_ready)
//   slave  : pad logic + stream FIFOs side
// Signals
//   fx2_din/fx2_dout/fx2_doe      FD bus, split into in/out/enable
//   fx2_addr                      FIFOADR[1:0]
//   fx2_sloe/slrd/slwr/pktend     active-low FX2 strobes
//   flag_ef / flag_ff             1 = EP2 not empty / EP6 not full
//   rx_data/rx_valid/rx_ready     words read from EP2
//   tx_data/tx_valid/tx_ready     words to write to EP6
//   grant                         00 idle/turn, 01 read, 10 write, 11 flush
// ---------------------------------------------------------------------------
interface fx2_slavefifo_arbiter_if;
   logic [15:0] fx2_din;
   logic [15:0] fx2_dout;
   logic        fx2_doe;
   logic [1:0]  fx2_addr;
   logic        fx2_sloe;
   logic        fx2_slrd;
   logic        fx2_slwr;
   logic        fx2_pktend;
   logic        flag_ef;
   logic        flag_ff;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [1:0]  grant;

   modport master (
      input  fx2_din, flag_ef, flag_ff, rx_ready, tx_data, tx_valid,
      output fx2_dout, fx2_doe, fx2_addr, fx2_sloe, fx2_slrd, fx2_slwr,
             fx2_pktend, rx_data, rx_valid, tx_ready, grant
   );

   modport slave (
      output fx2_din, flag_ef, flag_ff, rx_ready, tx_data, tx_valid,
      input  fx2_dout, fx2_doe, fx2_addr, fx2_sloe, fx2_slrd, fx2_slwr,
             fx2_pktend, rx_data, rx_valid, tx_ready, grant
   );
endinterface

// File: rtl/fx2_slavefifo_arbiter.sv
// ---------------------------------------------------------------------------
// fx2_slavefifo_arbiter
// Time-shares the FX2 synchronous slave-FIFO bus between the EP2 reader
// (host->FPGA) and the EP6 writer (FPGA->host). Sequences FIFOADR, SLOE,
// SLRD, SLWR, PKTEND and the bus turnaround between bursts. Contested grants
// alternate round-robin, the first one going to the read side.
// Ports
//   clk   FX2 interface clock (IFCLK domain), all logic on posedge
//   rst   synchronous, active-high reset
//   bus   fx2_slavefifo_arbiter_if.master (FX2 pads + rx/tx streams + grant)
// Configuration
//   FX2_PKTEND_FLUSH_EN : when defined, a partially filled EP6 packet is
//   committed with a PKTEND pulse after FLUSH_TO idle cycles (FLUSH state,
//   grant 11). When undefined, PKTEND is tied high and FLUSH_TO is absent.
// ---------------------------------------------------------------------------
module fx2_slavefifo_arbiter #(
   parameter logic [1:0] RD_ADDR   = 2'b00,
   parameter logic [1:0] WR_ADDR   = 2'b10,
   parameter int         BURST_MAX = 256,
   parameter int         TURN_CYC  = 2,
`ifdef FX2_PKTEND_FLUSH_EN
   parameter int         FLUSH_TO  = 1024,
`endif
   parameter int         PKT_WORDS = 256
) (
   input  logic                           clk,
   input  logic                           rst,
   fx2_slavefifo_arbiter_if.master        bus
);

   localparam int BW = $clog2(BURST_MAX + 1);
   localparam int WW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
   localparam int TW = 3;
`ifdef FX2_PKTEND_FLUSH_EN
   localparam int IW = $clog2(FLUSH_TO + 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_SETUP,
      S_RD_BURST,
      S_WR_SETUP,
      S_WR_BURST,
`ifdef FX2_PKTEND_FLUSH_EN
      S_FLUSH,
`endif
      S_TURN
   } state_e;

   state_e        state_q,     state_d;
   logic [1:0]    addr_q,      addr_d;
   logic          sloe_q,      sloe_d;
   logic          doe_q,       doe_d;
   logic          last_wr_q,   last_wr_d;    // 1 = previous burst belonged to the writer
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic [TW-1:0] turn_cnt_q,  turn_cnt_d;
   logic [WW-1:0] wr_words_q,  wr_words_d;   // position inside the current EP6 packet
`ifdef FX2_PKTEND_FLUSH_EN
   logic          flush_ph_q,  flush_ph_d;   // 0 = address settle, 1 = PKTEND strobe
   logic [IW-1:0] idle_cnt_q,  idle_cnt_d;
`endif

   logic          rd_pend, wr_pend;
   logic          rx_valid_c, tx_ready_c;
   logic          rd_xfer, wr_xfer;
   logic [1:0]    grant_c;

   assign rd_pend = bus.flag_ef & bus.rx_ready;
   assign wr_pend = bus.flag_ff & bus.tx_valid;

   // Handshakes are combinational from the registered state so a word moves
   // in the same cycle the flag reports it; rst masks them so a reset edge
   // never completes a transfer.
   assign rx_valid_c = (state_q == S_RD_BURST) & ~rst & bus.flag_ef;
   assign tx_ready_c = (state_q == S_WR_BURST) & ~rst & bus.flag_ff;
   assign rd_xfer    = rx_valid_c & bus.rx_ready;
   assign wr_xfer    = tx_ready_c & bus.tx_valid;

   assign bus.rx_valid = rx_valid_c;
   assign bus.tx_ready = tx_ready_c;
   assign bus.fx2_slrd = ~rd_xfer;
   assign bus.fx2_slwr = ~wr_xfer;
   assign bus.rx_data  = bus.fx2_din;
   assign bus.fx2_dout = bus.tx_data;
   assign bus.fx2_doe  = doe_q;
   assign bus.fx2_addr = addr_q;
   assign bus.fx2_sloe = sloe_q;
   assign bus.grant    = grant_c;

`ifdef FX2_PKTEND_FLUSH_EN
   assign bus.fx2_pktend = ~((state_q == S_FLUSH) & flush_ph_q & ~rst);
`else
   assign bus.fx2_pktend = 1'b1;
`endif

   always_comb begin
      grant_c = 2'b00;
      case (state_q)
         S_RD_SETUP, S_RD_BURST: grant_c = 2'b01;
         S_WR_SETUP, S_WR_BURST: grant_c = 2'b10;
`ifdef FX2_PKTEND_FLUSH_EN
         S_FLUSH:                grant_c = 2'b11;
`endif
         default:                grant_c = 2'b00;
      endcase
   end

   // NOTE: every signal written here gets a default first; a path that skips
   // an assignment would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      sloe_d      = sloe_q;
      doe_d       = doe_q;
      last_wr_d   = last_wr_q;
      burst_cnt_d = burst_cnt_q;
      turn_cnt_d  = turn_cnt_q;
      wr_words_d  = wr_words_q;

      if (wr_xfer) begin
         // Wrap at the packet size: this is where FX2 auto-commits the packet.
         wr_words_d = (wr_words_q == WW'(PKT_WORDS - 1)) ? '0 : wr_words_q + WW'(1);
      end

`ifdef FX2_PKTEND_FLUSH_EN
      flush_ph_d = flush_ph_q;
      idle_cnt_d = idle_cnt_q;
      if ((state_q == S_IDLE) && !wr_pend && (idle_cnt_q != IW'(FLUSH_TO))) begin
         idle_cnt_d = idle_cnt_q + IW'(1);
      end
`endif

      case (state_q)
         S_IDLE: begin
`ifdef FX2_PKTEND_FLUSH_EN
            if ((idle_cnt_q == IW'(FLUSH_TO)) && (wr_words_q != '0) && bus.flag_ff) begin
               state_d    = S_FLUSH;
               addr_d     = WR_ADDR;
               flush_ph_d = 1'b0;
            end else
`endif
            if (rd_pend && (!wr_pend || last_wr_q)) begin
               state_d     = S_RD_SETUP;
               addr_d      = RD_ADDR;
               sloe_d      = 1'b0;
               doe_d       = 1'b0;
               burst_cnt_d = '0;
            end else if (wr_pend) begin
               state_d     = S_WR_SETUP;
               addr_d      = WR_ADDR;
               sloe_d      = 1'b1;
               doe_d       = 1'b1;
               burst_cnt_d = '0;
`ifdef FX2_PKTEND_FLUSH_EN
               idle_cnt_d  = '0;
`endif
            end
         end

         S_RD_SETUP: state_d = S_RD_BURST;

         S_RD_BURST: begin
            if (rd_xfer) burst_cnt_d = burst_cnt_q + BW'(1);
            // A stall only gives up the bus when the writer is waiting for it.
            if ((rd_xfer && (burst_cnt_q == BW'(BURST_MAX - 1))) ||
                !bus.flag_ef || (!bus.rx_ready && wr_pend)) begin
               state_d    = S_TURN;
               sloe_d     = 1'b1;
               doe_d      = 1'b0;
               turn_cnt_d = '0;
               last_wr_d  = 1'b0;
            end
         end

         S_WR_SETUP: state_d = S_WR_BURST;

         S_WR_BURST: begin
            if (wr_xfer) burst_cnt_d = burst_cnt_q + BW'(1);
            if ((wr_xfer && (burst_cnt_q == BW'(BURST_MAX - 1))) ||
                !bus.flag_ff || (!bus.tx_valid && rd_pend)) begin
               state_d    = S_TURN;
               sloe_d     = 1'b1;
               doe_d      = 1'b0;
               turn_cnt_d = '0;
               last_wr_d  = 1'b1;
            end
         end

`ifdef FX2_PKTEND_FLUSH_EN
         S_FLUSH: begin
            if (!flush_ph_q) begin
               flush_ph_d = 1'b1;
            end else begin
               state_d    = S_TURN;
               turn_cnt_d = '0;
               flush_ph_d = 1'b0;
               wr_words_d = '0;
               idle_cnt_d = '0;
            end
         end
`endif

         S_TURN: begin
            if (turn_cnt_q == TW'(TURN_CYC - 1)) state_d = S_IDLE;
            else                                  turn_cnt_d = turn_cnt_q + TW'(1);
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= RD_ADDR;
         sloe_q      <= 1'b1;
         doe_q       <= 1'b0;
         last_wr_q   <= 1'b1;
         burst_cnt_q <= '0;
         turn_cnt_q  <= '0;
         wr_words_q  <= '0;
`ifdef FX2_PKTEND_FLUSH_EN
         flush_ph_q  <= 1'b0;
         idle_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         sloe_q      <= sloe_d;
         doe_q       <= doe_d;
         last_wr_q   <= last_wr_d;
         burst_cnt_q <= burst_cnt_d;
         turn_cnt_q  <= turn_cnt_d;
         wr_words_q  <= wr_words_d;
`ifdef FX2_PKTEND_FLUSH_EN
         flush_ph_q  <= flush_ph_d;
         idle_cnt_q  <= idle_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_fx2_slavefifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fx2_slavefifo_arbiter
// Directed bench for fx2_slavefifo_arbiter: read burst and turnaround,
// write burst limit, contention round-robin, backpressure, reset mid-burst
// and (with FX2_PKTEND_FLUSH_EN) the short-packet flush.
// ---------------------------------------------------------------------------
module tb_fx2_slavefifo_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int overlap_cnt   = 0;
   int pktend_lo_cnt = 0;
   int grant11_cnt   = 0;

   always #5 clk = ~clk;

   fx2_slavefifo_arbiter_if bus();

   fx2_slavefifo_arbiter #(
      .RD_ADDR   (2'b00),
      .WR_ADDR   (2'b10),
      .BURST_MAX (256),
      .TURN_CYC  (2),
`ifdef FX2_PKTEND_FLUSH_EN
      .FLUSH_TO  (16),
`endif
      .PKT_WORDS (256)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(negedge clk) begin
      if (!bus.fx2_sloe && bus.fx2_doe) overlap_cnt   <= overlap_cnt + 1;
      if (!bus.fx2_pktend)              pktend_lo_cnt <= pktend_lo_cnt + 1;
      if (bus.grant == 2'b11)           grant11_cnt   <= grant11_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.fx2_din  = '0;
      bus.flag_ef  = 1'b0;
      bus.flag_ff  = 1'b0;
      bus.rx_ready = 1'b0;
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"},    bus.grant,      2'b00);
      check({tag, "_addr"},     bus.fx2_addr,   2'b00);
      check({tag, "_sloe"},     bus.fx2_sloe,   1'b1);
      check({tag, "_slrd"},     bus.fx2_slrd,   1'b1);
      check({tag, "_slwr"},     bus.fx2_slwr,   1'b1);
      check({tag, "_pktend"},   bus.fx2_pktend, 1'b1);
      check({tag, "_doe"},      bus.fx2_doe,    1'b0);
      check({tag, "_rx_valid"}, bus.rx_valid,   1'b0);
      check({tag, "_tx_ready"}, bus.tx_ready,   1'b0);
   endtask

   // Writes n words then closes the burst with a one-cycle flag_ff drop if
   // the grant is still held; returns with the first TURN cycle sampled.
   task automatic write_words(input int n, output int got);
      got = 0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         bus.tx_valid = (got < n);
         bus.flag_ff  = !((got >= n) && (bus.grant == 2'b10));
         bus.tx_data  = 16'h7000 + 16'(got);
         settle();
         if (!bus.fx2_slwr) got++;
         if ((got >= n) && (bus.grant != 2'b10)) break;
      end
   endtask

   initial begin
      int words, n00, total, cur, nb, stall, nrec, rdw;
      int bursts [3];
      logic [1:0] rec [3];
      logic [1:0] prev;

      // ---------------- reset state ----------------
      do_reset();
      settle();
      check_reset_outputs("t0");

      // ---------------- 1: read only ----------------
      bus.flag_ef  = 1'b1;
      bus.rx_ready = 1'b1;
      settle();
      check("t1_idle_grant", bus.grant, 2'b00);
      tick(); settle();
      check("t1_setup_grant", bus.grant,    2'b01);
      check("t1_setup_sloe",  bus.fx2_sloe, 1'b0);
      check("t1_setup_addr",  bus.fx2_addr, 2'b00);
      check("t1_setup_doe",   bus.fx2_doe,  1'b0);
      check("t1_setup_slrd",  bus.fx2_slrd, 1'b1);
      words = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         bus.fx2_din = 16'hA000 + 16'(i);
         settle();
         if (!bus.fx2_slrd) words++;
         check("t1_rx_data", bus.rx_data, 32'hA000 + i);
      end
      check("t1_words", words, 10);
      tick();
      bus.flag_ef = 1'b0;
      settle();
      check("t1_empty_slrd",  bus.fx2_slrd, 1'b1);
      check("t1_empty_rxv",   bus.rx_valid, 1'b0);
      check("t1_empty_grant", bus.grant,    2'b01);
      tick(); settle();
      check("t1_turn_grant", bus.grant,    2'b00);
      check("t1_turn_sloe",  bus.fx2_sloe, 1'b1);
      check("t1_turn_addr",  bus.fx2_addr, 2'b00);
      // Re-request: TURN(2) + IDLE(1) must precede the next RD_SETUP.
      bus.flag_ef = 1'b1;
      n00 = 1;
      for (int c = 0; c < 20; c++) begin
         tick(); settle();
         if (bus.grant == 2'b00) n00++;
         else break;
      end
      check("t1_turn_len", n00, 3);
      check("t1_regrant", bus.grant, 2'b01);
      // Flag drops during SETUP: zero-word burst.
      bus.flag_ef = 1'b0;
      tick(); settle();
      check("t1_zero_slrd",  bus.fx2_slrd, 1'b1);
      check("t1_zero_grant", bus.grant,    2'b01);
      tick(); settle();
      check("t1_zero_exit", bus.grant, 2'b00);

      // ---------------- 2: write burst limit ----------------
      do_reset();
      total = 0; cur = 0; nb = 0; stall = 0; prev = 2'b00;
      for (int c = 0; c < 2000 && nb < 3; c++) begin
         tick();
         bus.tx_valid = (total < 600);
         bus.flag_ff  = (stall < 3);
         bus.tx_data  = 16'h5000 + 16'(total);
         settle();
         if ((bus.grant == 2'b10) && (prev != 2'b10)) begin
            check("t2_setup_doe",  bus.fx2_doe,  1'b1);
            check("t2_setup_addr", bus.fx2_addr, 2'b10);
            check("t2_setup_slwr", bus.fx2_slwr, 1'b1);
         end
         if (!bus.fx2_slwr) begin
            if (total == 0 || total == 599) check("t2_dout", bus.fx2_dout, 32'h5000 + total);
            total++;
            cur++;
         end
         if (!bus.tx_valid && bus.flag_ff) begin
            check("t2_stall_hold", bus.grant, 2'b10);
            stall++;
         end
         if ((prev == 2'b10) && (bus.grant != 2'b10)) begin
            bursts[nb] = cur;
            nb++;
            cur = 0;
         end
         prev = bus.grant;
      end
      check("t2_nbursts", nb, 3);
      check("t2_burst0", bursts[0], 256);
      check("t2_burst1", bursts[1], 256);
      check("t2_burst2", bursts[2], 88);
      check("t2_total",  total, 600);

      // ---------------- 3: contention ----------------
      do_reset();
      bus.flag_ef = 1'b1; bus.rx_ready = 1'b1;
      bus.flag_ff = 1'b1; bus.tx_valid = 1'b1;
      nrec = 0; rdw = 0; prev = 2'b00;
      rec[0] = 2'b00; rec[1] = 2'b00; rec[2] = 2'b00;
      for (int c = 0; c < 2000 && nrec < 3; c++) begin
         tick(); settle();
         if ((bus.grant != 2'b00) && (prev == 2'b00)) begin
            rec[nrec] = bus.grant;
            nrec++;
         end
         if ((nrec == 1) && !bus.fx2_slrd) rdw++;
         prev = bus.grant;
      end
      check("t3_grant0", rec[0], 2'b01);
      check("t3_grant1", rec[1], 2'b10);
      check("t3_grant2", rec[2], 2'b01);
      check("t3_rd_burst_len", rdw, 256);
      // Reader stalls while the writer waits: grant is released.
      tick(); settle();
      check("t3_rd_word", bus.fx2_slrd, 1'b0);
      tick();
      bus.rx_ready = 1'b0;
      settle();
      check("t3_stall_slrd",  bus.fx2_slrd, 1'b1);
      check("t3_stall_rxv",   bus.rx_valid, 1'b1);
      check("t3_stall_grant", bus.grant,    2'b01);
      tick(); settle();
      check("t3_stall_exit", bus.grant, 2'b00);
      tick(); tick(); tick(); settle();
      check("t3_write_after_stall", bus.grant, 2'b10);

      // ---------------- 4: backpressure ----------------
      do_reset();
      bus.flag_ff = 1'b1; bus.tx_valid = 1'b1;
      words = 0; prev = 2'b00;
      for (int c = 0; c < 200; c++) begin
         tick();
         bus.flag_ff = (words < 37);
         settle();
         if (!bus.fx2_slwr) words++;
         if (!bus.flag_ff && (bus.grant == 2'b10)) check("t4_full_slwr", bus.fx2_slwr, 1'b1);
         if ((prev == 2'b10) && (bus.grant != 2'b10)) break;
         prev = bus.grant;
      end
      check("t4_words", words, 37);
      check("t4_exit_grant", bus.grant, 2'b00);

`ifdef FX2_PKTEND_FLUSH_EN
      // ---------------- 5: short-packet flush ----------------
      do_reset();
      write_words(300, words);
      check("t5_words", words, 300);
      n00 = 0;
      for (int c = 0; c < 60; c++) begin
         tick(); settle();
         if (bus.grant == 2'b00) n00++;
         else break;
      end
      check("t5_wait_len",   n00, 18);
      check("t5_flush0_grant", bus.grant,      2'b11);
      check("t5_flush0_addr",  bus.fx2_addr,   2'b10);
      check("t5_flush0_pkt",   bus.fx2_pktend, 1'b1);
      tick(); settle();
      check("t5_flush1_addr",  bus.fx2_addr,   2'b10);
      check("t5_flush1_pkt",   bus.fx2_pktend, 1'b0);
      tick(); settle();
      check("t5_after_pkt",    bus.fx2_pktend, 1'b1);
      check("t5_after_grant",  bus.grant,      2'b00);
      do_reset();
      write_words(256, words);
      check("t5b_words", words, 256);
      for (int c = 0; c < 60; c++) tick();
      settle();
      check("t5_pktend_pulses", pktend_lo_cnt, 1);
      check("t5_flush_cycles",  grant11_cnt,   2);
`else
      settle();
      check("no_pktend_pulse", pktend_lo_cnt, 0);
      check("no_flush_grant",  grant11_cnt,   0);
`endif

      // ---------------- 6: reset mid-burst ----------------
      do_reset();
      bus.flag_ef = 1'b1; bus.rx_ready = 1'b1;
      words = 0;
      for (int c = 0; c < 20 && words < 4; c++) begin
         tick(); settle();
         if (!bus.fx2_slrd) words++;
      end
      check("t6_words", words, 4);
      tick();
      rst = 1'b1;
      settle();
      check("t6_rst_slrd", bus.fx2_slrd, 1'b1);
      check("t6_rst_rxv",  bus.rx_valid, 1'b0);
      tick();
      rst = 1'b0;
      bus.flag_ef = 1'b0; bus.rx_ready = 1'b0;
      settle();
      check_reset_outputs("t6");

      check("no_sloe_doe_overlap", overlap_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
